// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: opcode width,
// the decoded opcodes that can stall, and the jump bubble counter width.
package stall_ctrl_pkg;

  localparam int unsigned OPW   = 6;
  localparam int unsigned CNT_W = 3;  // holds JMP_BUBBLES-1, legal range 1..7

  localparam logic [OPW-1:0] OP_HLT = 6'b010001;
  localparam logic [OPW-1:0] OP_LD  = 6'b010111;
  localparam logic [OPW-1:0] OP_JMP = 6'b001101;

endpackage

// File: rtl/stall_control_module_bubble_counter.sv
// bubble_counter: counts down the extra stall cycles after a jump.
//   clk     : clock
//   rst_n   : async active-low reset
//   load_i  : jump accepted this cycle; loads BUBBLES-1
//   clr_i   : decode no longer holds a jump; clears done when idle
//   busy_o  : count is non-zero (bubble still in progress)
//   done_o  : jump fully serviced; blocks a held jump from re-stalling
module bubble_counter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned BUBBLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clr_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(BUBBLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q;

  // Load on accept, count down while busy, clear done once the jump leaves decode.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (load_i) begin
      cnt_d  = LoadVal;
      done_d = (LoadVal == '0);  // single-bubble jump is finished immediately
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end else if (clr_i) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/stall_control_module.sv
// stall_control_module: generates pipeline stall requests from the opcode
// in decode (halt, load-use, jump bubbles).
//   clk      : clock, all state on rising edge
//   reset    : async active-low reset
//   op_dec   : opcode in decode stage
//   stall    : combinational stall to fetch/decode registers
//   stall_pm : stall delayed one clock, to program-memory stage
// Build option: define STALL_CTRL_JUMP_BUBBLE_EN to make JMP insert
// JMP_BUBBLES stall cycles; otherwise JMP does not stall.
module stall_control_module #(
  parameter int unsigned OPW         = stall_ctrl_pkg::OPW,
  parameter int unsigned JMP_BUBBLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op_dec,
  output logic           stall,
  output logic           stall_pm
);

  import stall_ctrl_pkg::*;

  logic is_hlt, is_ld;
  logic halted_q, halted_d;
  logic ld_done_q, ld_done_d;
  logic ld_hit;
  logic jmp_stall;
  logic stall_pm_q;

  assign is_hlt = (op_dec == OPW'(OP_HLT));
  assign is_ld  = (op_dec == OPW'(OP_LD));
  assign ld_hit = is_ld & ~ld_done_q;

`ifdef STALL_CTRL_JUMP_BUBBLE_EN
  logic is_jmp, jmp_hit, jmp_busy, jmp_done;

  assign is_jmp  = (op_dec == OPW'(OP_JMP));
  assign jmp_hit = is_jmp & ~jmp_done & ~jmp_busy;

  bubble_counter #(
    .BUBBLES (JMP_BUBBLES)
  ) u_bubble_counter (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (jmp_hit),
    .clr_i  (~is_jmp),
    .busy_o (jmp_busy),
    .done_o (jmp_done)
  );

  assign jmp_stall = jmp_hit | jmp_busy;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(JMP_BUBBLES)};
  assign jmp_stall  = 1'b0;
`endif

  // Halt is sticky until reset; a held load stalls only on its first cycle.
  always_comb begin
    halted_d  = halted_q;
    ld_done_d = 1'b0;
    if (is_hlt) halted_d = 1'b1;
    if (is_ld)  ld_done_d = 1'b1;
  end

  assign stall = halted_q | is_hlt | ld_hit | jmp_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      stall_pm_q <= 1'b0;
    end else begin
      halted_q   <= halted_d;
      ld_done_q  <= ld_done_d;
      stall_pm_q <= stall;
    end
  end

  assign stall_pm = stall_pm_q;

endmodule

// File: tb/tb_stall_control_module.sv
// Directed bench for stall_control_module. Expected jump behaviour follows
// STALL_CTRL_JUMP_BUBBLE_EN so the same bench covers both builds.
module tb_stall_control_module;

`ifdef STALL_CTRL_JUMP_BUBBLE_EN
  localparam logic J = 1'b1;
`else
  localparam logic J = 1'b0;
`endif

  localparam logic [5:0] HLT = 6'b010001;
  localparam logic [5:0] LD  = 6'b010111;
  localparam logic [5:0] JMP = 6'b001101;
  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] OTH = 6'b001010;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_dec;
  logic       stall;
  logic       stall_pm;

  int total = 0;
  int bad   = 0;

  stall_control_module #(
    .OPW         (6),
    .JMP_BUBBLES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_dec   (op_dec),
    .stall    (stall),
    .stall_pm (stall_pm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one decode opcode, check both outputs, then move past the next edge.
  task automatic cyc(input logic [5:0] op, input logic es, input logic ep, input string tag);
    op_dec = op;
    #1;
    chk({tag, ".stall"}, stall, es);
    chk({tag, ".stall_pm"}, stall_pm, ep);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    op_dec = NOP;
    #2;
    chk("rst_early.stall", stall, 1'b0);
    chk("rst_early.stall_pm", stall_pm, 1'b0);
    #10;
    chk("rst_late.stall", stall, 1'b0);
    chk("rst_late.stall_pm", stall_pm, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // non-stalling code
    cyc(OTH, 1'b0, 1'b0, "oth1");
    cyc(OTH, 1'b0, 1'b0, "oth2");

    // held load stalls once; a gap re-arms it
    cyc(LD,  1'b1, 1'b0, "ld1a");
    cyc(LD,  1'b0, 1'b1, "ld1b");
    cyc(NOP, 1'b0, 1'b0, "ld_gap");
    cyc(LD,  1'b1, 1'b0, "ld2a");
    cyc(NOP, 1'b0, 1'b1, "ld2b");

    // held jump: two bubbles then no re-stall
    cyc(JMP, J,    1'b0, "j0");
    cyc(JMP, J,    J,    "j1");
    cyc(JMP, 1'b0, J,    "j2");
    cyc(JMP, 1'b0, 1'b0, "j3");
    cyc(NOP, 1'b0, 1'b0, "j_end");

    // reset in the middle of a jump bubble
    cyc(JMP, J, 1'b0, "rb0");
    reset = 1'b0;
    op_dec = JMP;
    #1;
    chk("rb_rst_jmp.stall", stall, J);
    chk("rb_rst_jmp.stall_pm", stall_pm, 1'b0);
    op_dec = NOP;
    #1;
    chk("rb_rst_nop.stall", stall, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(NOP, 1'b0, 1'b0, "rb_fresh");

    // halt arriving in a jump bubble still latches
    cyc(JMP, J,    1'b0, "hj0");
    cyc(HLT, 1'b1, J,    "hj1");
    cyc(NOP, 1'b1, 1'b1, "halt1");
    cyc(LD,  1'b1, 1'b1, "halt2");
    cyc(JMP, 1'b1, 1'b1, "halt3");
    cyc(OTH, 1'b1, 1'b1, "halt4");

    // reset while halted clears everything; only comb hits remain
    reset  = 1'b0;
    op_dec = NOP;
    #1;
    chk("hrst_nop.stall", stall, 1'b0);
    chk("hrst_nop.stall_pm", stall_pm, 1'b0);
    op_dec = LD;
    #1;
    chk("hrst_ld.stall", stall, 1'b1);
    chk("hrst_ld.stall_pm", stall_pm, 1'b0);
    op_dec = NOP;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    cyc(NOP, 1'b0, 1'b0, "post1");
    cyc(OTH, 1'b0, 1'b0, "post2");
    cyc(HLT, 1'b1, 1'b0, "post_hlt");
    cyc(NOP, 1'b1, 1'b1, "post_halted");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stall_control_module.md
STALL_CONTROL_MODULE -- requirements
Module: stall_control_module

Interface
REQ-001 Parameter OPW, default 6: opcode width.
REQ-002 Parameter JMP_BUBBLES, default 2: stall cycles inserted per jump (legal 1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op_dec  input  OPW  opcode currently in decode stage; stable between rising edges.
REQ-006 stall  output  1  combinational stall request to fetch/decode pipeline registers.
REQ-007 stall_pm  output  1  registered stall to program-memory stage: stall delayed one clk.

Function
REQ-008 Opcode decode SHALL be by exact OPW-bit match: HLT=6'b010001, LD=6'b010111, JMP=6'b001101; all other codes, including 6'b000000 and 6'b001010, are non-stalling.
REQ-009 Halt: op_dec==HLT SHALL assert stall in the same cycle and set a halted flag on the next edge; halted SHALL hold stall=1 until reset, regardless of op_dec.
REQ-010 Load: op_dec==LD with ld_done=0 SHALL assert stall combinationally for exactly one cycle; ld_done sets on that edge.
REQ-011 ld_done SHALL clear on any edge where op_dec!=LD; a held LD opcode SHALL NOT re-stall; two LDs SHALL be separated by a non-LD opcode.
REQ-012 Jump: op_dec==JMP with jmp_done=0 and jmp_cnt==0 SHALL assert stall combinationally and load jmp_cnt=JMP_BUBBLES-1.
REQ-013 While jmp_cnt!=0, stall SHALL be 1 and jmp_cnt SHALL decrement each edge; when it reaches 0, jmp_done sets. Total jump stall = JMP_BUBBLES cycles.
REQ-014 jmp_done SHALL clear on any edge where op_dec!=JMP and jmp_cnt==0.
REQ-015 stall = halted | hlt_hit | ld_hit | jmp_hit | (jmp_cnt!=0).
REQ-016 stall_pm SHALL equal the value of stall sampled at the previous rising edge.
REQ-017 Simultaneous sources SHALL OR together; HLT arriving during a jump bubble SHALL still latch halted.

Reset
REQ-018 While reset=0: stall_pm=0, halted=0, ld_done=0, jmp_done=0, jmp_cnt=0, asynchronously.
REQ-019 stall during reset SHALL reflect only combinational hits from op_dec.
REQ-020 Reset asserted mid-bubble or while halted SHALL abort all pending stalls; the first edge after release behaves as a fresh start.

Configuration
REQ-021 Macro STALL_CTRL_JUMP_BUBBLE_EN: defined, jump logic of REQ-012..014 is compiled in; undefined, JMP is non-stalling and jmp_cnt/jmp_done are absent.

Structure
REQ-022 Opcode constants (HLT, LD, JMP) and OPW SHALL reside in shared package stall_ctrl_pkg.
REQ-023 Jump bubble counter SHALL be a sub-module bubble_counter (load, decrement, busy, done outputs).

Verification
REQ-024 reset low 5-15 ns, op_dec=0 -> stall=0, stall_pm=0 throughout.
REQ-025 op_dec=6'b001010 held two cycles -> stall=0, stall_pm=0.
REQ-026 op_dec=6'b001101 held (macro defined, JMP_BUBBLES=2) -> stall=1 for 2 cycles then 0; stall_pm same pattern one cycle later.
REQ-027 op_dec=6'b010111 held two cycles -> stall=1 first cycle only; stall_pm=1 in second cycle only.
REQ-028 op_dec=6'b010001 then 6'b000000 -> stall=1 from HLT cycle onward permanently; stall_pm=1 from next cycle; reset low clears both.
REQ-029 Macro undefined, op_dec=6'b001101 -> stall=0, stall_pm=0.
